seq_restoring_divider: RTL and testbench

Multi-cycle unsigned integer divider built on a ripple subtract/restore step, one quotient bit per clock. It computes quotient and remainder of `dividend / divisor` under a start/done handshake. It sits in the combinational arithmetic library as the iterative inverse of the adder chain, for datapaths that need division without a wide single-cycle array.

---
 rtl/seq_restoring_divider.sv | 172 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient
// bit per clock, start/done handshake. Results are held until the next completion.
// Optional feature macro: DIVIDER_ZERO_DETECT_EN. When it is defined, a zero
// divisor finishes one cycle after start and raises div_by_zero. When it is
// undefined, div_by_zero is tied low and a zero divisor runs all iterations.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Iteration counter must hold WIDTH itself.
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

`ifdef DIVIDER_ZERO_DETECT_EN
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
`endif

  // One subtract/restore step. The shifted partial remainder keeps its carry-out
  // bit so that divisors above half of the range still compare correctly.
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // Datapath for the current iteration.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    fits     = (rem_sh >= {1'b0, dvs_q});
    rem_step = fits ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], fits};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIVIDER_ZERO_DETECT_EN
    zero_d      = zero_q;
    dbz_d       = dbz_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef DIVIDER_ZERO_DETECT_EN
          zero_d  = (divisor == '0);
`endif
        end
      end

      CALC: begin
`ifdef DIVIDER_ZERO_DETECT_EN
        if (zero_q) begin
          // Zero divisor skips the iterations. quo_q still holds the dividend.
          quotient_d  = '1;
          remainder_d = quo_q;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          zero_d      = 1'b0;
          state_d     = IDLE;
        end else begin
`endif
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient_d  = quo_step;
            remainder_d = rem_step;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
`ifdef DIVIDER_ZERO_DETECT_EN
            dbz_d       = 1'b0;
`endif
          end
`ifdef DIVIDER_ZERO_DETECT_EN
        end
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset discards any division in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIVIDER_ZERO_DETECT_EN
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

`ifdef DIVIDER_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider. A reference quotient and remainder
// are computed with plain / and %. A monitor pops the expected results on each done.
module tb_seq_restoring_divider;

  localparam int unsigned W     = 8;
  localparam int unsigned NRAND = 2000;
  localparam int unsigned MAXV  = (1 << W) - 1;
`ifdef DIVIDER_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
    bit          dbz;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint unsigned act,
                              input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: compare each completion against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.dbz);
        chk("latency", cyc - mon_e.acc, mon_e.lat);
        chk("busy_at_done", busy, 0);
        if (mon_e.b != 0)
          chk("invariant",
              ((int'(quotient) * mon_e.b + int'(remainder) == mon_e.a) &&
               (int'(remainder) < mon_e.b)) ? 1 : 0, 1);
      end
    end
  end

  // Drive one start cycle. The expectation is queued only if the DUT is idle.
  task automatic do_start(input int unsigned a, input int unsigned b);
    exp_t e;
    bit   accepted;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    accepted = !busy;
    if (accepted) begin
      e.a   = a;
      e.b   = b;
      e.q   = (b == 0) ? MAXV : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.dbz = (b == 0) && ZD;
      e.acc = cyc + 1;
      e.lat = ((b == 0) && ZD) ? 1 : W;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (accepted) chk("busy_after_start", busy, 1);
  endtask

  // Advance to the first negedge with busy low, which is the done cycle.
  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned ra, rb;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic directed cases.
    do_start(200, 7); wait_idle(W + 4); @(negedge clk);
    chk("done_clears", done, 0);
    chk("quotient_holds", quotient, 28);
    chk("remainder_holds", remainder, 4);
    do_start(255, 1); wait_idle(W + 4); @(negedge clk);
    do_start(5, 9);   wait_idle(W + 4); @(negedge clk);
    do_start(100, 0); wait_idle(W + 4); @(negedge clk);
    chk("zero_quotient_holds", quotient, MAXV);

    // A start while busy is ignored; a start during the done cycle is accepted.
    do_start(200, 7);
    repeat (2) @(negedge clk);
    chk("busy_before_ignored_start", busy, 1);
    do_start(50, 6);
    wait_idle(W + 4);
    do_start(50, 6);
    wait_idle(W + 4); @(negedge clk);
    chk("b2b_quotient_holds", quotient, 8);

    // Asynchronous reset in the middle of a division.
    do_start(200, 7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("no_done_after_rst", done, 0);
    do_start(200, 7); wait_idle(W + 4); @(negedge clk);

    // Randomized back-to-back sweep with nonzero divisors.
    for (int i = 0; i < int'(NRAND); i++) begin
      ra = $urandom_range(0, MAXV);
      rb = (i % 2 == 0) ? $urandom_range(1, 15) : $urandom_range(1, MAXV);
      do_start(ra, rb);
      wait_idle(W + 4);
    end
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
